// File: rtl/fetch_seq_pkg.sv
// Shared state encoding and default widths for the instruction-fetch sequencer.
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_CNT_W   = 32;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: jump target beats a taken branch, which beats a plain increment.
module pc_next_calc
  import fetch_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              branch,
  input  logic              zero,
  input  logic [ADDR_W-1:0] sign_ext,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] pc_inc;

  // All arithmetic wraps modulo 2^ADDR_W; a negative offset is just a large addend.
  assign pc_inc = pc + ADDR_W'(1);

  always_comb begin
    next_pc = pc_inc;
    if (jump)
      next_pc = jump_target;
    else if (branch && zero)
      next_pc = pc_inc + sign_ext;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Handshake-paced fetch controller: owns the PC, holds the fetched instruction
// for the datapath and commits the next PC once execution finishes.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_FETCH  | im_req high at pc, waiting for im_ack
//   ST_EXEC   | instr valid; waiting for stall low to commit
//   ST_HALTED | HALT committed; parked until reset
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  output logic               im_req,
  output logic [ADDR_W-1:0]  im_addr,
  input  logic               im_ack,
  input  logic [INSTR_W-1:0] im_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               stall,
  input  logic               branch,
  input  logic               zero,
  input  logic [ADDR_W-1:0]  sign_ext,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               halt,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] next_pc;

  pc_next_calc #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc          (pc),
    .branch      (branch),
    .zero        (zero),
    .sign_ext    (sign_ext),
    .jump        (jump),
    .jump_target (jump_target),
    .next_pc     (next_pc)
  );

  // Gated by reset so an in-flight request is withdrawn in the reset cycle itself.
  assign im_req  = (state == ST_FETCH) && !reset;
  assign im_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      retired     <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (im_ack) begin
            instr       <= im_rdata;
            instr_valid <= 1'b1;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!stall) begin
            if (retired != '1)
              retired <= retired + CNT_W'(1);
            instr_valid <= 1'b0;
            if (halt) begin
              halted <= 1'b1;
              state  <= ST_HALTED;
            end else begin
              pc    <= next_pc;
              state <= ST_FETCH;
            end
          end
        end
        ST_HALTED: ;
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule
